maxpool_stream: RTL and testbench

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

---
 rtl/maxpool_stream.sv | 113 +++++++++++
 tb/tb_maxpool_stream.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// maxpool_stream: 2x2 stride-2 signed max pooling over a row-major pixel stream.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 416,
  parameter int IMG_HEIGHT = 416
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LD = IMG_WIDTH / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] lb_idx;

  logic signed [DATA_WIDTH-1:0] pair;
  logic signed [DATA_WIDTH-1:0] pix;
  logic signed [DATA_WIDTH-1:0] hmax;
  logic signed [DATA_WIDTH-1:0] lb_q;
  logic signed [DATA_WIDTH-1:0] pooled;
  logic signed [DATA_WIDTH-1:0] result;
  logic signed [DATA_WIDTH-1:0] line_buf [LD];

  logic in_fire;
  logic out_fire;
  logic load;
  logic load_last;

  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign lb_idx    = LW'(col >> 1);
  assign lb_q      = line_buf[lb_idx];
  assign pix       = $signed(in_data);
  assign load      = in_fire && col[0] && row[0];
  assign load_last = load && (col == COL_MAX) && (row == ROW_MAX);

  // Horizontal max, vertical max and optional clamp of the pooled value
  always_comb begin
    hmax   = (pix > pair) ? pix : pair;
    pooled = (hmax > lb_q) ? hmax : lb_q;
`ifdef MAXPOOL_RELU_EN
    result = pooled[DATA_WIDTH-1] ? '0 : pooled;
`else
    result = pooled;
`endif
  end

  // Column/row position and the even-column pair register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      pair <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      pair <= '0;
    end else if (in_fire) begin
      if (!col[0]) begin
        pair <= pix;
      end
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Even-row horizontal maxima; every entry is written before it is read
  always_ff @(posedge clk) begin
    if (in_fire && !clear && col[0] && !row[0]) begin
      line_buf[lb_idx] <= hmax;
    end
  end

  // Output register: a new load wins over a drain, stall holds everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_last  <= load_last;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: randomized self-checking bench for maxpool_stream.
// Pooled results come from a frame-level reference model.
module tb_maxpool_stream;

  localparam int DW   = 16;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  typedef logic [DW-1:0] frame_t [NPIX];

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW:0] exp_q [$];
  logic [DW:0] obs_q [$];

  always #5 clk = ~clk;

  maxpool_stream #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  // capture every output transfer as {last, data}
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      obs_q.push_back({out_last, out_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int smax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // reference: max over each 2x2 block, row-major, last on final block
  function automatic void model(input frame_t f);
    int m;
    int a;
    logic lst;
    logic [DW-1:0] v;
    for (int r = 0; r < H; r += 2) begin
      for (int c = 0; c < W; c += 2) begin
        a = r * W + c;
        m = smax(smax(int'($signed(f[a])), int'($signed(f[a+1]))),
                 smax(int'($signed(f[a+W])), int'($signed(f[a+W+1]))));
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        lst = (r == H - 2) && (c == W - 2);
        v = m[DW-1:0];
        exp_q.push_back({lst, v});
      end
    end
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < NPIX; i++) f[i] = DW'($urandom);
    return f;
  endfunction

  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < NPIX; i++) send(f[i]);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    repeat (2) begin
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", out_valid);
      else n_pass++;
      n_total++;
      if (out_data !== '0) $display("FAIL rst_data got=%h want=0", out_data);
      else n_pass++;
      n_total++;
      if (out_last !== 1'b0) $display("FAIL rst_last got=%b want=0", out_last);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL rst_ready got=%b want=1", in_ready);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    frame_t f;
    int idx;
    logic is_out;
    for (int i = 0; i < NPIX; i++) f[i] = DW'(i);
    exp_q.delete();
    obs_q.delete();
    model(f);
    idx = 0;
    for (int k = 0; k < NPIX; k++) begin
      send(f[k]);
      is_out = ((k / W) % 2 == 1) && ((k % W) % 2 == 1);
      n_total++;
      if (out_valid !== is_out)
        $display("FAIL basic_valid px=%0d got=%b want=%b", k, out_valid, is_out);
      else n_pass++;
      if (is_out && idx < exp_q.size()) begin
        n_total++;
        if (out_data !== exp_q[idx][DW-1:0])
          $display("FAIL basic_data px=%0d got=%h want=%h", k, out_data, exp_q[idx][DW-1:0]);
        else n_pass++;
        n_total++;
        if (out_last !== exp_q[idx][DW])
          $display("FAIL basic_last px=%0d got=%b want=%b", k, out_last, exp_q[idx][DW]);
        else n_pass++;
        idx++;
      end
    end
    drain();
    n_total++;
    if (obs_q.size() != 4) $display("FAIL basic_count got=%0d want=4", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_window(input string name, input logic [DW-1:0] p0,
                             input logic [DW-1:0] p1, input logic [DW-1:0] p2,
                             input logic [DW-1:0] p3, input logic [DW-1:0] want);
    frame_t f;
    logic [DW:0] o;
    logic [DW-1:0] v;
    f = rand_frame();
    f[0] = p0;
    f[1] = p1;
    f[W] = p2;
    f[W+1] = p3;
    exp_q.delete();
    obs_q.delete();
    model(f);
    send_frame(f);
    drain();
    v = (obs_q.size() > 0) ? obs_q[0][DW-1:0] : 'x;
    n_total++;
    if (v !== want) $display("FAIL %s_first got=%h want=%h", name, v, want);
    else n_pass++;
    n_total++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL %s_count got=%0d want=%0d", name, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_total++;
      if (o !== exp_q[i]) $display("FAIL %s_out%0d got=%h want=%h", name, i, o, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_signed();
    test_window("signed", 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h7FFF);
  endtask

  task automatic test_negative();
`ifdef MAXPOOL_RELU_EN
    test_window("negative", 16'hFFFB, 16'hFFFD, 16'hFFF7, 16'hFFFC, 16'h0000);
`else
    test_window("negative", 16'hFFFB, 16'hFFFD, 16'hFFF7, 16'hFFFC, 16'hFFFD);
`endif
  endtask

  task automatic test_stall();
    frame_t f;
    logic [DW:0] o;
    f = rand_frame();
    exp_q.delete();
    obs_q.delete();
    model(f);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(f[k]);
    in_valid = 1'b1;
    in_data  = f[6];
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL stall_valid cyc=%0d got=%b want=1", c, out_valid);
      else n_pass++;
      n_total++;
      if (out_data !== exp_q[0][DW-1:0])
        $display("FAIL stall_data cyc=%0d got=%h want=%h", c, out_data, exp_q[0][DW-1:0]);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL stall_ready cyc=%0d got=%b want=0", c, in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release got=%b want=1", in_ready);
    else n_pass++;
    for (int k = 6; k < NPIX; k++) send(f[k]);
    drain();
    n_total++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_total++;
      if (o !== exp_q[i]) $display("FAIL stall_out%0d got=%h want=%h", i, o, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    frame_t f;
    logic [DW:0] o;
    for (int k = 0; k < 6; k++) send(DW'($urandom));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NPIX; i++) f[i] = DW'(i);
    exp_q.delete();
    obs_q.delete();
    model(f);
    send_frame(f);
    drain();
    n_total++;
    if (obs_q.size() != 4) $display("FAIL rstmid_count got=%0d want=4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_total++;
      if (o !== exp_q[i]) $display("FAIL rstmid_out%0d got=%h want=%h", i, o, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    frame_t f;
    logic [DW:0] o;
    for (int k = 0; k < 6; k++) send(DW'($urandom));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL clear_valid got=%b want=0", out_valid);
    else n_pass++;
    f = rand_frame();
    exp_q.delete();
    obs_q.delete();
    model(f);
    send_frame(f);
    drain();
    n_total++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL clear_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_total++;
      if (o !== exp_q[i]) $display("FAIL clear_out%0d got=%h want=%h", i, o, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1;
    frame_t f2;
    logic [DW:0] o;
    time t0;
    time dt;
    f1 = rand_frame();
    f2 = rand_frame();
    exp_q.delete();
    obs_q.delete();
    model(f1);
    model(f2);
    t0 = $time;
    send_frame(f1);
    send_frame(f2);
    dt = $time - t0;
    n_total++;
    if (dt != 320) $display("FAIL b2b_time got=%0t want=320", dt);
    else n_pass++;
    drain();
    n_total++;
    if (obs_q.size() != 8) $display("FAIL b2b_count got=%0d want=8", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < obs_q.size()) ? obs_q[i] : 'x;
      n_total++;
      if (o !== exp_q[i]) $display("FAIL b2b_out%0d got=%h want=%h", i, o, exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_negative();
    test_stall();
    test_reset_mid();
    test_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
